// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame geometry, command bytes and parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StSend,
    StWaitIdle
  } ps2_state_e;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned FRAME_EDGES = 11;

  localparam logic [7:0] CMD_LEDS  = 8'hED;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line with a falling-edge strobe on the synced level.
module ps2_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-edge frame and acknowledge check.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2dat,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] ParityEdge = 4'(DATA_BITS + 1);
  localparam logic [3:0] StopEdge   = 4'(FRAME_EDGES - 1);

  logic clk_lvl, clk_fall, dat_lvl, dat_fall_unused;

  ps2_sync_edge u_sync_clk (
    .clk_i   (clk),
    .rst_i   (reset),
    .d_i     (ps2clk),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_sync_edge u_sync_dat (
    .clk_i   (clk),
    .rst_i   (reset),
    .d_i     (ps2dat),
    .level_o (dat_lvl),
    .fall_o  (dat_fall_unused)
  );

  ps2_state_e         state_q, state_d;
  logic [DATA_BITS:0] shift_q, shift_d;
  logic [3:0]         edge_cnt_q, edge_cnt_d;
  logic [InhW-1:0]    inh_cnt_q, inh_cnt_d;
  logic [ToW-1:0]     to_cnt_q, to_cnt_d;
  logic               clk_oe_q, clk_oe_d;
  logic               dat_oe_q, dat_oe_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ack_ok_q, ack_ok_d;
  logic               busy_q, busy_d;
  logic [3:0]         edge_n;

  assign edge_n = edge_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    edge_cnt_d = edge_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    ack_ok_d   = ack_ok_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    busy_d     = (done_q || err_q) ? 1'b0 : busy_q;

    unique case (state_q)
      StIdle: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid && !busy_q) begin
          state_d    = StInhibit;
          shift_d    = {odd_parity(tx_data), tx_data};
          edge_cnt_d = '0;
          inh_cnt_d  = '0;
          clk_oe_d   = 1'b1;
          busy_d     = 1'b1;
        end
      end
      StInhibit: begin
        if (32'(inh_cnt_q) + 32'd1 >= INHIBIT_CYCLES) begin
          dat_oe_d = 1'b1;
          state_d  = StRts;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      StRts: begin
        clk_oe_d = 1'b0;
        to_cnt_d = '0;
        state_d  = StSend;
      end
      StSend, StWaitIdle: begin
        if (32'(to_cnt_q) >= TIMEOUT_CYCLES) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          state_d  = StIdle;
        end else begin
          to_cnt_d = clk_fall ? '0 : to_cnt_q + 1'b1;
          if (state_q == StSend) begin
            if (clk_fall) begin
              edge_cnt_d = edge_n;
              if (edge_n <= ParityEdge) begin
                dat_oe_d = ~shift_q[0];
                shift_d  = shift_q >> 1;
              end else if (edge_n == StopEdge) begin
                dat_oe_d = 1'b0;
              end else begin
                // Edge 11: the device holds data low to acknowledge.
                ack_ok_d = ~dat_lvl;
                dat_oe_d = 1'b0;
                state_d  = StWaitIdle;
              end
            end
          end else if (clk_lvl && dat_lvl) begin
            done_d  = ack_ok_q;
            err_d   = ~ack_ok_q;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      edge_cnt_q <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_ok_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      edge_cnt_q <= edge_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ack_ok_q   <= ack_ok_d;
      busy_q     <= busy_d;
    end
  end

  assign ps2clk_oe = clk_oe_q;
  assign ps2dat_oe = dat_oe_q;
  assign tx_done   = done_q;
  assign tx_err    = err_q;
  assign busy      = busy_q;
  assign tx_ready  = ~busy_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: table of command frames plus random bytes against an open-drain device model.
module tb_ps2_tx;

  localparam int unsigned Inh = 20;
  localparam int unsigned To  = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2clk, ps2dat, ps2clk_oe, ps2dat_oe;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, tx_done, tx_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_total = 0, err_total = 0, both_total = 0;
  int exp_done_total = 0, exp_err_total = 0;

  // Open-drain wired-AND of host and device pull-downs.
  assign ps2clk = ~(ps2clk_oe | dev_clk_low);
  assign ps2dat = ~(ps2dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  ps2_tx #(
    .INHIBIT_CYCLES (Inh),
    .TIMEOUT_CYCLES (To)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2clk    (ps2clk),
    .ps2dat    (ps2dat),
    .ps2clk_oe (ps2clk_oe),
    .ps2dat_oe (ps2dat_oe),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_err    (tx_err)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_done) done_total++;
      if (tx_err) err_total++;
      if (tx_done && tx_err) both_total++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line levels the device should see at edges 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] expected_levels(input logic [7:0] d);
    logic [9:0] e;
    for (int i = 0; i < 8; i++) e[i] = (d / (1 << i)) % 2 == 1;
    e[8] = ($countones(d) % 2) == 0;
    e[9] = 1'b1;
    return e;
  endfunction

  task automatic device_frame(input int abort_at, input bit ack, output logic [9:0] lv);
    lv = '0;
    repeat (5) @(posedge clk);
    for (int n = 1; n <= 11; n++) begin
      #2 dev_clk_low = 1'b1;
      if (n == abort_at) begin
        repeat (6) @(posedge clk);
        return;
      end
      repeat (8) @(posedge clk);
      #2 dev_clk_low = 1'b0;
      if (n == 11) begin
        dev_dat_low = 1'b0;
        break;
      end
      repeat (8) @(posedge clk);
      lv[n-1] = ps2dat;
      if (n == 10 && ack) begin
        dev_dat_low = 1'b1;
        repeat (2) @(posedge clk);
      end
    end
  endtask

  task automatic wait_pulse(input int bound, output int cyc, output bit got);
    got = 1'b0;
    cyc = 0;
    while (cyc < bound) begin
      @(negedge clk);
      if (tx_done || tx_err) begin
        got = 1'b1;
        break;
      end
      cyc++;
    end
  endtask

  task automatic run_frame(input logic [7:0] data, input bit ack, input bit silent,
                           input bit spam, input int abort_at);
    int         hold, dfirst, cyc, stray;
    bit         got, exp_done;
    logic [9:0] lv;
    exp_done = ack && !silent;
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = data;
    @(posedge clk); #1;
    if (spam) tx_data = data ^ 8'h5A;
    else begin
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
    end
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", tx_ready, 0);
    hold = 0;
    dfirst = -1;
    while (hold < 10000) begin
      @(negedge clk);
      if (!ps2clk_oe) break;
      if (ps2dat_oe && dfirst < 0) dfirst = hold;
      hold++;
    end
    tx_valid = 1'b0;
    check("clock_hold_cycles", hold, Inh + 1);
    check("rts_cycle_index", dfirst, Inh);
    check("start_bit_low", ps2dat_oe, 1);
    if (abort_at > 0) begin
      device_frame(abort_at, 1'b1, lv);
      check("driving_before_reset", ps2dat_oe, 1);
      #3 reset = 1'b1;
      #1;
      check("reset_async_oe", {ps2clk_oe, ps2dat_oe}, 2'b00);
      check("reset_async_ready", {tx_ready, busy}, 2'b10);
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(posedge clk);
      return;
    end
    if (silent) begin
      wait_pulse(To + 50, cyc, got);
      check("timeout_pulse_seen", got, 1);
      check("timeout_latency_window", (cyc >= To - 1 && cyc <= To + 1), 1);
    end else begin
      device_frame(0, ack, lv);
      check($sformatf("frame_levels_%02h", data), lv, expected_levels(data));
      wait_pulse(200, cyc, got);
      check("end_pulse_seen", got, 1);
    end
    if (exp_done) exp_done_total++;
    else exp_err_total++;
    if (got) begin
      check("pulse_kind", {tx_done, tx_err}, exp_done ? 2'b10 : 2'b01);
      check("busy_at_pulse", busy, 1);
      check("lines_released", {ps2clk_oe, ps2dat_oe}, 2'b00);
      @(negedge clk);
      check("ready_after_pulse", {tx_ready, busy, tx_done, tx_err}, 4'b1000);
    end
    if (spam) begin
      stray = 0;
      repeat (30) begin
        @(negedge clk);
        if (ps2clk_oe || busy) stray++;
      end
      check("no_second_transfer", stray, 0);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         silent;
    bit         spam;
  } vec_t;

  initial begin
    vec_t vecs[5];
    vecs[0] = '{data: 8'hED, ack: 1'b1, silent: 1'b0, spam: 1'b0};
    vecs[1] = '{data: 8'h02, ack: 1'b1, silent: 1'b0, spam: 1'b0};
    vecs[2] = '{data: 8'hA5, ack: 1'b1, silent: 1'b1, spam: 1'b0};
    vecs[3] = '{data: 8'h81, ack: 1'b0, silent: 1'b0, spam: 1'b0};
    vecs[4] = '{data: 8'h3C, ack: 1'b1, silent: 1'b0, spam: 1'b1};

    repeat (3) @(negedge clk);
    check("reset_oe", {ps2clk_oe, ps2dat_oe}, 2'b00);
    check("reset_ready_busy", {tx_ready, busy}, 2'b10);
    check("reset_pulses", {tx_done, tx_err}, 2'b00);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {ps2clk_oe, ps2dat_oe, tx_ready}, 3'b001);

    for (int i = 0; i < 5; i++)
      run_frame(vecs[i].data, vecs[i].ack, vecs[i].silent, vecs[i].spam, 0);

    for (int i = 0; i < 6; i++)
      run_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0, 1'b0, 1'b0, 0);

    run_frame(8'h00, 1'b1, 1'b0, 1'b0, 5);
    run_frame(8'hFF, 1'b1, 1'b0, 1'b0, 0);

    repeat (5) @(negedge clk);
    check("done_total", done_total, exp_done_total);
    check("err_total", err_total, exp_err_total);
    check("never_both_pulses", both_total, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter. Sends one command byte from the FPGA to the attached keyboard, for example the LED command 0xED or reset 0xFF. It uses the standard inhibit/request-to-send sequence, odd parity, and acknowledge check. It sits beside the PS/2 receiver on the same two open-drain lines and drives them only through active-high pull-low enables.

## Interface
Parameters:
- INHIBIT_CYCLES, default 2500: clk cycles the PS/2 clock is held low before request-to-send (≥100 µs; 2500 at 25 MHz).
- TIMEOUT_CYCLES, default 375000: maximum clk cycles allowed between consecutive device falling edges, and from request-to-send to the first edge (15 ms at 25 MHz).

Ports:
- clk, in, 1: system clock. One clock domain.
- reset, in, 1: asynchronous, active-high reset.
- ps2clk, in, 1: raw PS/2 clock line level, asynchronous.
- ps2dat, in, 1: raw PS/2 data line level, asynchronous.
- ps2clk_oe, out, 1: 1 = pull PS/2 clock low, 0 = release.
- ps2dat_oe, out, 1: 1 = pull PS/2 data low, 0 = release.
- tx_valid, in, 1: command byte request.
- tx_data, in, 8: command byte.
- tx_ready, out, 1: block is idle and can accept a byte.
- busy, out, 1: transfer in progress; the receiver discards frames while this is high.
- tx_done, out, 1: one-cycle pulse when the byte was acknowledged.
- tx_err, out, 1: one-cycle pulse on missing acknowledge or timeout.

## Operation
- ps2clk and ps2dat pass through two synchronizer flops each. A falling edge is detected as previous synced level 1 and current synced level 0.
- At accept, the frame shift register loads {parity, tx_data}, with parity = ~^tx_data (odd parity). A 4-bit counter tracks device falling edges.
- IDLE:
  - tx_ready=1, busy=0, both oe=0.
  - Accept when tx_valid && tx_ready. Go to INHIBIT, load the inhibit counter with 0.
- INHIBIT:
  - ps2clk_oe=1, ps2dat_oe=0.
  - After INHIBIT_CYCLES cycles, set ps2dat_oe=1 (start bit) and go to RTS.
- RTS:
  - ps2clk_oe=1 and ps2dat_oe=1 for exactly one cycle.
  - Then release the clock (ps2clk_oe=0) with data still held low, clear the timeout counter, and go to SEND.
- SEND: on each falling edge n (n=1..11):
  - n=1..8: ps2dat_oe = ~data bit n-1, LSB first.
  - n=9: ps2dat_oe = ~parity.
  - n=10: ps2dat_oe=0 (stop bit; line released).
  - n=11: sample synced ps2dat. If 0, go to WAIT_IDLE with ack ok. If 1, go to WAIT_IDLE with ack failed.
- WAIT_IDLE:
  - Both oe=0.
  - Wait until synced ps2clk=1 and ps2dat=1, then pulse tx_done (ack ok) or tx_err (ack failed) and return to IDLE.
- Timeout: in RTS/SEND/WAIT_IDLE, the timeout counter clears on every falling edge. When it reaches TIMEOUT_CYCLES:
  - release both lines;
  - pulse tx_err;
  - go to IDLE.
- tx_valid while not tx_ready is ignored; no queueing.
- tx_data is captured only at accept; later changes have no effect.

## Timing
- Reset values: ps2clk_oe=0, ps2dat_oe=0, tx_ready=1, busy=0, tx_done=0, tx_err=0. State is IDLE and all counters are 0.
- Reset asserted mid-transfer releases both lines asynchronously. No pulse is issued.
- Edge-to-action latency: 3 clk cycles from a ps2clk pin fall to the ps2dat_oe update (2 synchronizer stages plus 1 registered output).
- busy=1 from the cycle after accept until the cycle tx_done or tx_err pulses, inclusive.
- tx_ready = ~busy. The earliest next accept is the cycle after the done/error pulse.
- Accept to first device edge: INHIBIT_CYCLES + 1 cycles of hold before the clock is released.
- tx_done and tx_err are never high together; exactly one fires per accepted byte.
- Both counters are sized $clog2(param+1) bits and saturate, never wrap.

## Structure
- A shared ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, RTS, SEND, WAIT_IDLE);
  - the bit-count constants (DATA_BITS=8, FRAME_EDGES=11);
  - command constants CMD_LEDS=8'hED and CMD_RESET=8'hFF.
- One sub-module, ps2_sync_edge: a 2-flop synchronizer plus falling-edge detector. It is instantiated twice and is reusable by the receiver.

## Test plan
- Send 0xED with a device model that acks:
  - data low at edges 1..8 follows LSB-first 1,0,1,1,0,1,1,1;
  - parity driven 1 (line released) at edge 9;
  - line released at edge 10;
  - tx_done pulses once, busy falls.
- Send 0x02 (parity 0): at edge 9 ps2dat_oe=1; the frame completes with tx_done.
- Device never clocks after request-to-send → tx_err pulses after TIMEOUT_CYCLES; both oe=0; tx_ready=1.
- Device leaves data high at edge 11 → tx_err, no tx_done.
- tx_valid asserted during busy with a different byte → ignored; the original byte is transmitted; no second transfer starts.
- Assert reset during SEND at edge 5 → both oe=0 immediately; after release, a new 0xFF transfer completes normally.
